matmul_c_writer: RTL and testbench
==================================

// Module: matmul_c_writer
// PURPOSE
//  Result-drain side of the 8x8 systolic matmul. The 8x8 matmul reads A/B from BRAM through its address ports.
//  This block is the matching writer: it captures the two C row outputs while the array shifts them out and
//  writes them into two C BRAM ports (one per 4x4 row block), with address generation and a small elastic FIFO
//  to absorb write back-pressure. It sits between the matmul top level and the C memories.
// PARAMETERS
//  DWIDTH        8   element width (bits)
//  AWIDTH        7   C memory address width
//  MAT_MUL_SIZE  4   building-block size; each row port is MAT_MUL_SIZE*DWIDTH bits wide
//  NUM_WORDS     8   words captured per row port per result (= final matrix size)
//  FIFO_DEPTH    4   entries; one entry holds both rows (power of 2, >=2)
// PORTS
//  clk            in   1      clock
//  reset          in   1      asynchronous, active-low reset
//  done_mat_mul   in   1      matmul completion; its rising edge starts a drain
//  c_base_addr    in   AWIDTH first C write address; sampled at drain start
//  c_data_valid   in   1      c_data_row_* hold a valid output word this cycle
//  c_data_row_0   in   32     row-block 0 result word
//  c_data_row_1   in   32     row-block 1 result word
//  mem_ready      in   1      C memories accept a write this cycle
//  c_addr_0/1     out  AWIDTH write address, ports 0/1 (always equal)
//  c_wdata_0/1    out  32     write data, ports 0/1
//  c_we_0/1       out  1      write enable, ports 0/1 (always equal)
//  busy           out  1      high in DRAIN and FLUSH
//  done_write     out  1      one-cycle pulse when the drain completes
//  overflow       out  1      sticky; a word was dropped on a full FIFO
// BEHAVIOUR
//  Reset (async, reset==0): all outputs 0, FSM=IDLE, FIFO empty, counters 0, overflow cleared, edge detector cleared.
//  FSM IDLE -> DRAIN on the done_mat_mul rising edge (registered previous value). Load wr_addr=c_base_addr, in_cnt=0.
//   DRAIN: each c_data_valid cycle counts (in_cnt++); when in_cnt reaches NUM_WORDS -> FLUSH.
//   FLUSH: when FIFO is empty and no write is pending -> DONE.
//   DONE: done_write=1 for exactly this cycle -> IDLE.
//  Outside DRAIN, c_data_valid is ignored. A done_mat_mul edge outside IDLE is ignored (no queueing).
//  Push: in DRAIN with c_data_valid, the entry {row_1,row_0} is pushed.
//   If the FIFO is full and no pop occurs this cycle, the word is dropped, overflow<=1, and in_cnt still increments.
//   A push and a pop in the same cycle on a full FIFO is legal; no drop occurs.
//  Pop: when the FIFO is non-empty and mem_ready==1, the head is popped. On the next edge the outputs register:
//   c_we_*<=1, c_wdata_0/1<=head row 0/1, c_addr_*<=wr_addr, and wr_addr<=wr_addr+1.
//   Otherwise c_we_*<=0; addr and wdata hold their last values.
//  Latency: a valid word at cycle t into an empty FIFO with mem_ready high gives c_we at cycle t+2.
//  Writes occur in arrival order. At most one write per cycle.
//  Address arithmetic is modulo 2^AWIDTH (wraps 0x7F->0x00 for AWIDTH=7).
//  No write ever occurs with mem_ready low in the pop cycle.
// TESTING
//  1. Base 0x10, 8 back-to-back valid words, mem_ready=1 -> 8 writes/port at addrs 0x10..0x17.
//     Data matches in order; done_write pulses one cycle after the last c_we; overflow=0.
//  2. mem_ready=0 for the whole stream of 8 words -> first 4 stored, overflow=1.
//     After mem_ready rises: 4 writes at base..base+3 carrying words 0..3, then done_write.
//  3. Base 0x7C, mem_ready=1 -> write addresses 7C,7D,7E,7F,00,01,02,03.
//  4. Valid on alternate cycles, plus mem_ready=0 for 3 cycles mid-stream -> all 8 words written in order.
//     No overflow; busy is high throughout.
//  5. reset pulled low during DRAIN after 3 words -> all outputs 0 immediately.
//     The next done_mat_mul edge starts a clean 8-word drain from the new c_base_addr.
//  6. done_mat_mul held high for 40 cycles -> exactly one drain and one done_write pulse.

Source files
------------

// File: rtl/matmul_c_writer.sv
// Drain side of the 8x8 systolic matmul: captures C row pairs into an elastic FIFO
// and replays them as in-order writes to the two C BRAM ports.

// Generic synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
// Latency: one cycle from push to the entry becoming visible at rdata.
// Backpressure: full/empty flags; the caller decides what to do with a refused push.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end
endmodule

// C-matrix writer: one drain per done_mat_mul rising edge, NUM_WORDS row pairs per drain.
// Latency: valid word at cycle t reaches c_we at t+2 when the FIFO is empty and mem_ready is high.
// Backpressure: mem_ready gates pops; pushes into a full FIFO are dropped and flagged in overflow.
module matmul_c_writer #(
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 7,
  parameter int MAT_MUL_SIZE = 4,
  parameter int NUM_WORDS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           done_mat_mul,
  input  logic [AWIDTH-1:0]              c_base_addr,
  input  logic                           c_data_valid,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] c_data_row_0,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] c_data_row_1,
  input  logic                           mem_ready,
  output logic [AWIDTH-1:0]              c_addr_0,
  output logic [AWIDTH-1:0]              c_addr_1,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] c_wdata_0,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] c_wdata_1,
  output logic                           c_we_0,
  output logic                           c_we_1,
  output logic                           busy,
  output logic                           done_write,
  output logic                           overflow
);
  localparam int ROW_W = MAT_MUL_SIZE * DWIDTH;
  localparam int CW    = $clog2(NUM_WORDS + 1);

  typedef struct packed {
    logic [ROW_W-1:0] row_1;
    logic [ROW_W-1:0] row_0;
  } entry_t;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              done_prev;
  logic              start;
  logic [CW-1:0]     in_cnt;
  logic [AWIDTH-1:0] wr_addr;
  logic [AWIDTH-1:0] addr_q;
  logic [ROW_W-1:0]  wdata0_q;
  logic [ROW_W-1:0]  wdata1_q;
  logic              we_q;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  entry_t            push_entry;
  entry_t            head;

  assign start      = done_mat_mul && !done_prev;
  assign push       = (state == DRAIN) && c_data_valid;
  assign pop        = !fifo_empty && mem_ready;
  assign push_entry = '{row_1: c_data_row_1, row_0: c_data_row_0};

  sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (push),
    .wdata (push_entry),
    .rd_en (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done_write = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = DRAIN;
      DRAIN: begin
        busy = 1'b1;
        // The last word is counted even if it gets dropped on a full FIFO.
        if (c_data_valid && in_cnt == CW'(NUM_WORDS - 1)) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (fifo_empty && !pop) state_nxt = DONE;
      end
      DONE: begin
        done_write = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      done_prev <= 1'b0;
      in_cnt    <= '0;
      wr_addr   <= '0;
      addr_q    <= '0;
      wdata0_q  <= '0;
      wdata1_q  <= '0;
      we_q      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      done_prev <= done_mat_mul;
      we_q      <= pop;
      if (pop) begin
        addr_q   <= wr_addr;
        wdata0_q <= head.row_0;
        wdata1_q <= head.row_1;
        wr_addr  <= wr_addr + 1'b1;
      end
      if (state == IDLE && start) begin
        wr_addr <= c_base_addr;
        in_cnt  <= '0;
      end else if (push) begin
        in_cnt <= in_cnt + 1'b1;
      end
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign c_addr_0  = addr_q;
  assign c_addr_1  = addr_q;
  assign c_wdata_0 = wdata0_q;
  assign c_wdata_1 = wdata1_q;
  assign c_we_0    = we_q;
  assign c_we_1    = we_q;
endmodule

// File: tb/tb_matmul_c_writer.sv
// Directed bench for matmul_c_writer: expected writes queued at issue, checked by a negedge monitor.
module tb_matmul_c_writer;
  logic        clk = 1'b0;
  logic        reset;
  logic        done_mat_mul;
  logic [6:0]  c_base_addr;
  logic        c_data_valid;
  logic [31:0] c_data_row_0;
  logic [31:0] c_data_row_1;
  logic        mem_ready;
  logic [6:0]  c_addr_0, c_addr_1;
  logic [31:0] c_wdata_0, c_wdata_1;
  logic        c_we_0, c_we_1;
  logic        busy, done_write, overflow;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errs = 0;
  int   done_cnt = 0;
  logic done_after_we = 1'b0;
  logic we_d = 1'b0;
  logic mr_d = 1'b0;

  matmul_c_writer dut (
    .clk          (clk),
    .reset        (reset),
    .done_mat_mul (done_mat_mul),
    .c_base_addr  (c_base_addr),
    .c_data_valid (c_data_valid),
    .c_data_row_0 (c_data_row_0),
    .c_data_row_1 (c_data_row_1),
    .mem_ready    (mem_ready),
    .c_addr_0     (c_addr_0),
    .c_addr_1     (c_addr_1),
    .c_wdata_0    (c_wdata_0),
    .c_wdata_1    (c_wdata_1),
    .c_we_0       (c_we_0),
    .c_we_1       (c_we_1),
    .busy         (busy),
    .done_write   (done_write),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_row(input logic [3:0] t, input int i, input logic r);
    logic [7:0] ib;
    ib = 8'(i);
    return {4'hA, 3'b000, r, 4'h0, t, ib, 8'h5A ^ ib};
  endfunction

  // Scoreboard monitor: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (c_we_0) begin
      chk("write_needs_ready", {127'd0, mr_d}, 128'd1);
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_write: addr %h data %h/%h with empty scoreboard", c_addr_0, c_wdata_0, c_wdata_1);
      end else begin
        e = q.pop_front();
        chk("write", {49'd0, c_we_1, c_addr_0, c_addr_1, c_wdata_0, c_wdata_1},
            {49'd0, 1'b1, e.addr, e.addr, e.d0, e.d1});
      end
    end
    if (done_write) begin
      done_cnt++;
      done_after_we = we_d;
    end
    we_d = c_we_0;
    mr_d = mem_ready;
  end

  task automatic start_drain(input logic [6:0] base);
    @(posedge clk); #1;
    c_base_addr  = base;
    done_mat_mul = 1'b1;
    @(posedge clk); #1;
    done_mat_mul = 1'b0;
  endtask

  // Sends n words with gap idle cycles between them; the first nexp are expected as writes.
  task automatic send_words(input logic [3:0] t, input int n, input int gap, input int nexp,
                            input logic [6:0] base);
    exp_t e;
    for (int i = 0; i < nexp; i++) begin
      e.addr = base + 7'(i);
      e.d0   = mk_row(t, i, 1'b0);
      e.d1   = mk_row(t, i, 1'b1);
      q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      c_data_valid = 1'b1;
      c_data_row_0 = mk_row(t, i, 1'b0);
      c_data_row_1 = mk_row(t, i, 1'b1);
      @(posedge clk); #1;
      c_data_valid = 1'b0;
      c_data_row_0 = '0;
      c_data_row_1 = '0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(input int d0, input string nm);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk({nm, "_done_pulses"}, 128'(done_cnt - d0), 128'd1);
    chk({nm, "_done_after_last_we"}, {127'd0, done_after_we}, 128'd1);
    chk({nm, "_sb_empty"}, 128'(q.size()), 128'd0);
    @(negedge clk); #1;
    chk({nm, "_pulse_width"}, {126'd0, done_write, busy}, 128'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("reset_pulse_outputs", {71'd0, c_we_0, c_we_1, busy, done_write, overflow, c_addr_0, c_addr_1, c_wdata_0},
        128'd0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int lows;
    reset        = 1'b0;
    done_mat_mul = 1'b0;
    c_base_addr  = '0;
    c_data_valid = 1'b0;
    c_data_row_0 = '0;
    c_data_row_1 = '0;
    mem_ready    = 1'b0;
    #12;
    chk("reset_ctrl", {123'd0, c_we_0, c_we_1, busy, done_write, overflow}, 128'd0);
    chk("reset_data", {50'd0, c_addr_0, c_addr_1, c_wdata_0, c_wdata_1}, 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: back-to-back stream, memory always ready
    mem_ready = 1'b1;
    d0 = done_cnt;
    start_drain(7'h10);
    chk("t1_busy", {127'd0, busy}, 128'd1);
    send_words(4'h1, 8, 0, 8, 7'h10);
    wait_done(d0, "t1");
    chk("t1_overflow", {127'd0, overflow}, 128'd0);

    // 2: memory stalled for the whole stream; only the first FIFO_DEPTH words survive
    mem_ready = 1'b0;
    d0 = done_cnt;
    start_drain(7'h20);
    send_words(4'h2, 8, 0, 4, 7'h20);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t2_overflow", {127'd0, overflow}, 128'd1);
    chk("t2_no_write_while_stalled", 128'(q.size()), 128'd4);
    chk("t2_busy_stalled", {127'd0, busy}, 128'd1);
    mem_ready = 1'b1;
    wait_done(d0, "t2");
    chk("t2_overflow_sticky", {127'd0, overflow}, 128'd1);
    pulse_reset();

    // 3: address wrap
    d0 = done_cnt;
    start_drain(7'h7C);
    send_words(4'h3, 8, 0, 8, 7'h7C);
    wait_done(d0, "t3");

    // 4: alternate-cycle valid with a 3-cycle mid-stream stall
    d0 = done_cnt;
    lows = 0;
    start_drain(7'h60);
    fork
      send_words(4'h4, 8, 1, 8, 7'h60);
      begin
        repeat (5) begin
          @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
        end
        mem_ready = 1'b1;
      end
      begin
        repeat (16) begin
          @(negedge clk);
          if (!busy) lows++;
        end
      end
    join
    chk("t4_busy_low_cycles", 128'(lows), 128'd0);
    wait_done(d0, "t4");
    chk("t4_overflow", {127'd0, overflow}, 128'd0);

    // 5: reset in the middle of a drain, then a clean drain
    mem_ready = 1'b0;
    start_drain(7'h30);
    send_words(4'h5, 3, 0, 0, 7'h30);
    reset = 1'b0;
    #1;
    chk("t5_reset_ctrl", {123'd0, c_we_0, c_we_1, busy, done_write, overflow}, 128'd0);
    chk("t5_reset_data", {50'd0, c_addr_0, c_addr_1, c_wdata_0, c_wdata_1}, 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    mem_ready = 1'b1;
    d0 = done_cnt;
    start_drain(7'h40);
    send_words(4'h6, 8, 0, 8, 7'h40);
    wait_done(d0, "t5");

    // 6: done_mat_mul held high for 40 cycles
    d0 = done_cnt;
    @(posedge clk); #1;
    c_base_addr  = 7'h50;
    done_mat_mul = 1'b1;
    @(posedge clk); #1;
    send_words(4'h7, 8, 0, 8, 7'h50);
    repeat (31) begin
      @(posedge clk); #1;
    end
    done_mat_mul = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("t6_single_drain", 128'(done_cnt - d0), 128'd1);
    chk("t6_idle", {127'd0, busy}, 128'd0);

    chk("final_sb_empty", 128'(q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end
endmodule
